// File: rtl/axis_sched.sv
// axis_sched: runs each inertial sample through a shared PID engine one axis at a time
// (pitch, roll, yaw) and publishes the three terms together. Define AXIS_SCHED_TMO_EN for the WAIT timeout.
module axis_sched #(
  parameter int TMO_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic signed [15:0] d_ptch,
  input  logic signed [15:0] d_roll,
  input  logic signed [15:0] d_yaw,
  input  logic               inertial_cal,
  output logic               pid_go,
  output logic [1:0]         pid_axis,
  output logic signed [15:0] pid_act,
  output logic signed [15:0] pid_des,
  input  logic               pid_done,
  input  logic signed [9:0]  pid_res,
  output logic signed [9:0]  ptch_term,
  output logic signed [9:0]  roll_term,
  output logic signed [9:0]  yaw_term,
  output logic               terms_vld,
  output logic               busy,
  output logic [7:0]         ovr_cnt,
  output logic               tmo_err
);

  // state   | meaning
  // IDLE    | waiting for a sample
  // ISSUE   | pid_go pulse for the current axis
  // WAIT    | waiting for pid_done (or timeout) on the current axis
  // PUBLISH | terms_vld pulse, terms stable from here until the next PUBLISH
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_axis;
  logic signed [15:0] r_ptch, r_roll, r_yaw;
  logic signed [15:0] r_d_ptch, r_d_roll, r_d_yaw;
  logic signed [9:0]  r_acc_p, r_acc_r;
  logic signed [9:0]  r_ptch_term, r_roll_term, r_yaw_term;
  logic               r_pid_go;
  logic               r_terms_vld;
  logic               r_busy;
  logic               r_cal_hold;
  logic [7:0]         r_ovr_cnt;

  logic               w_tmo_hit;
  logic               w_step;
  logic signed [9:0]  w_res;

`ifdef AXIS_SCHED_TMO_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_err;

  // Loaded while in ISSUE so WAIT always starts with a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state == ISSUE) begin
        r_tmo_cnt <= TW'(TMO_CYC - 1);
      end else if ((r_state == WAIT) && (r_tmo_cnt != '0)) begin
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
      if (w_tmo_hit) begin
        r_tmo_err <= 1'b1;
      end
    end
  end

  assign w_tmo_hit = (r_state == WAIT) && !pid_done && (r_tmo_cnt == '0);
  assign tmo_err   = r_tmo_err;
`else
  // No timeout hardware in this build; the compare is constant-false for any legal TMO_CYC.
  assign w_tmo_hit = (TMO_CYC < 0);
  assign tmo_err   = 1'b0;
`endif

  assign w_step = (r_state == WAIT) && (pid_done || w_tmo_hit);
  assign w_res  = pid_done ? pid_res : 10'sd0;

  always_comb begin
    pid_act = r_ptch;
    pid_des = r_d_ptch;
    case (r_axis)
      2'd1: begin
        pid_act = r_roll;
        pid_des = r_d_roll;
      end
      2'd2: begin
        pid_act = r_yaw;
        pid_des = r_d_yaw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_axis      <= 2'd0;
      r_ptch      <= '0;
      r_roll      <= '0;
      r_yaw       <= '0;
      r_d_ptch    <= '0;
      r_d_roll    <= '0;
      r_d_yaw     <= '0;
      r_acc_p     <= '0;
      r_acc_r     <= '0;
      r_ptch_term <= '0;
      r_roll_term <= '0;
      r_yaw_term  <= '0;
      r_pid_go    <= 1'b0;
      r_terms_vld <= 1'b0;
      r_busy      <= 1'b0;
      r_cal_hold  <= 1'b0;
    end else begin
      r_pid_go    <= 1'b0;
      r_terms_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (vld) begin
            r_busy <= 1'b1;
            if (inertial_cal) begin
              r_ptch_term <= '0;
              r_roll_term <= '0;
              r_yaw_term  <= '0;
              r_cal_hold  <= 1'b1;
              r_state     <= PUBLISH;
            end else begin
              r_ptch   <= ptch;
              r_roll   <= roll;
              r_yaw    <= yaw;
              r_d_ptch <= d_ptch;
              r_d_roll <= d_roll;
              r_d_yaw  <= d_yaw;
              r_axis   <= 2'd0;
              r_pid_go <= 1'b1;
              r_state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_step) begin
            case (r_axis)
              2'd0: begin
                r_acc_p  <= w_res;
                r_axis   <= 2'd1;
                r_pid_go <= 1'b1;
                r_state  <= ISSUE;
              end
              2'd1: begin
                r_acc_r  <= w_res;
                r_axis   <= 2'd2;
                r_pid_go <= 1'b1;
                r_state  <= ISSUE;
              end
              default: begin
                r_ptch_term <= r_acc_p;
                r_roll_term <= r_acc_r;
                r_yaw_term  <= w_res;
                r_terms_vld <= 1'b1;
                r_state     <= PUBLISH;
              end
            endcase
          end
        end
        PUBLISH: begin
          // A calibration publish spends one extra cycle here before pulsing terms_vld.
          if (r_cal_hold) begin
            r_cal_hold  <= 1'b0;
            r_terms_vld <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_cnt <= 8'd0;
    end else if (vld && (r_state != IDLE) && (r_ovr_cnt != 8'hFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  assign pid_go    = r_pid_go;
  assign pid_axis  = r_axis;
  assign ptch_term = r_ptch_term;
  assign roll_term = r_roll_term;
  assign yaw_term  = r_yaw_term;
  assign terms_vld = r_terms_vld;
  assign busy      = r_busy;
  assign ovr_cnt   = r_ovr_cnt;

endmodule

// File: tb/tb_axis_sched.sv
// tb_axis_sched: table-driven directed bench for axis_sched with a small PID responder,
// plus hand-written overrun, reset-abort, stray-done and (with AXIS_SCHED_TMO_EN) timeout sequences.
module tb_axis_sched;

`ifdef AXIS_SCHED_TMO_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld = 1'b0;
  logic signed [15:0] ptch = '0, roll = '0, yaw = '0;
  logic signed [15:0] d_ptch = '0, d_roll = '0, d_yaw = '0;
  logic               inertial_cal = 1'b0;
  logic               pid_go;
  logic [1:0]         pid_axis;
  logic signed [15:0] pid_act, pid_des;
  logic               pid_done = 1'b0;
  logic signed [9:0]  pid_res = '0;
  logic signed [9:0]  ptch_term, roll_term, yaw_term;
  logic               terms_vld, busy;
  logic [7:0]         ovr_cnt;
  logic               tmo_err;

  int n_cmp = 0;
  int n_bad = 0;

  axis_sched #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld),
    .ptch(ptch), .roll(roll), .yaw(yaw),
    .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
    .inertial_cal(inertial_cal),
    .pid_go(pid_go), .pid_axis(pid_axis), .pid_act(pid_act), .pid_des(pid_des),
    .pid_done(pid_done), .pid_res(pid_res),
    .ptch_term(ptch_term), .roll_term(roll_term), .yaw_term(yaw_term),
    .terms_vld(terms_vld), .busy(busy), .ovr_cnt(ovr_cnt), .tmo_err(tmo_err)
  );

  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int p, r, y, dp, dr, dy;
    int cal;
    int k;
    int res0, res1, res2;
    int ep, er, ey;
    int lat;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_act(input vec_t v, input int ax);
    return (ax == 0) ? v.p : (ax == 1) ? v.r : v.y;
  endfunction

  function automatic int exp_des(input vec_t v, input int ax);
    return (ax == 0) ? v.dp : (ax == 1) ? v.dr : v.dy;
  endfunction

  function automatic int res_of(input vec_t v, input int ax);
    return (ax == 0) ? v.res0 : (ax == 1) ? v.res1 : (ax == 2) ? v.res2 : 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_go"}, pid_go, 0);
    check({tag, "_axis"}, pid_axis, 0);
    check({tag, "_act"}, pid_act, 0);
    check({tag, "_des"}, pid_des, 0);
    check({tag, "_pterm"}, ptch_term, 0);
    check({tag, "_rterm"}, roll_term, 0);
    check({tag, "_yterm"}, yaw_term, 0);
    check({tag, "_tv"}, terms_vld, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovr"}, ovr_cnt, 0);
    check({tag, "_tmo"}, tmo_err, 0);
  endtask

  // One sample from vld to the cycle after terms_vld; the bench plays the PID engine.
  task automatic run_seq(input vec_t v, input bit spam, input bit done_at_go,
                         input bit abort_ax1, input bit skip_roll);
    int n, ngo, done_at, go_cyc, lat;
    bit fin;
    ptch = 16'(v.p);  roll = 16'(v.r);  yaw = 16'(v.y);
    d_ptch = 16'(v.dp); d_roll = 16'(v.dr); d_yaw = 16'(v.dy);
    inertial_cal = (v.cal != 0);
    vld = 1'b1;
    tick();
    vld = 1'b0;
    n = 1; ngo = 0; done_at = -1; go_cyc = -100; lat = -1; fin = 1'b0;
    while (!fin && n < v.lat + 40) begin
      if (pid_go) begin
        check($sformatf("go%0d_axis", ngo), pid_axis, ngo);
        check($sformatf("go%0d_act", ngo), pid_act, exp_act(v, ngo));
        check($sformatf("go%0d_des", ngo), pid_des, exp_des(v, ngo));
        go_cyc = n;
        done_at = (skip_roll && ngo == 1) ? -1 : n + v.k;
        ngo++;
      end
      if (n == done_at) begin
        check($sformatf("hold%0d_axis", ngo - 1), pid_axis, ngo - 1);
        check($sformatf("hold%0d_act", ngo - 1), pid_act, exp_act(v, ngo - 1));
        check($sformatf("hold%0d_des", ngo - 1), pid_des, exp_des(v, ngo - 1));
      end
      if (terms_vld) begin
        lat = n;
        fin = 1'b1;
      end
      if (abort_ax1 && ngo == 2 && n == go_cyc + 1) begin
        vld = 1'b0;
        pid_done = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        return;
      end
      pid_done = (n == done_at) || (done_at_go && n == go_cyc);
      pid_res = (n == done_at) ? 10'(res_of(v, ngo - 1)) : 10'sd99;
      if (spam && busy) begin
        vld = 1'b1;
        ptch = 16'sh1357; roll = -16'sd999; yaw = 16'sd4242;
        d_ptch = -16'sd1; d_roll = 16'sd2; d_yaw = -16'sd3;
        inertial_cal = 1'b1;
      end else begin
        vld = 1'b0;
      end
      tick();
      n++;
    end
    pid_done = 1'b0;
    vld = 1'b0;
    inertial_cal = 1'b0;
    check("go_count", ngo, (v.cal != 0) ? 0 : 3);
    check("latency", lat, v.lat);
    check("ptch_term", ptch_term, v.ep);
    check("roll_term", roll_term, v.er);
    check("yaw_term", yaw_term, v.ey);
    check("post_busy", busy, 0);
    check("post_tv", terms_vld, 0);
  endtask

  initial begin
    int tv_cnt;
    tbl[0] = '{p:100, r:-20, y:7, dp:40, dr:0, dy:7, cal:0, k:3,
               res0:12, res1:-5, res2:0, ep:12, er:-5, ey:0, lat:13};
    tbl[1] = '{p:1, r:2, y:3, dp:4, dr:5, dy:6, cal:1, k:3,
               res0:0, res1:0, res2:0, ep:0, er:0, ey:0, lat:2};
    tbl[2] = '{p:-32768, r:32767, y:0, dp:32767, dr:-32768, dy:-1, cal:0, k:1,
               res0:511, res1:-512, res2:1, ep:511, er:-512, ey:1, lat:7};
    tbl[3] = '{p:500, r:-500, y:9, dp:1, dr:2, dy:3, cal:1, k:2,
               res0:0, res1:0, res2:0, ep:0, er:0, ey:0, lat:2};
    tbl[4] = '{p:-300, r:1234, y:-4321, dp:300, dr:-1234, dy:4321, cal:0, k:5,
               res0:-1, res1:100, res2:-300, ep:-1, er:100, ey:-300, lat:19};
    tbl[5] = '{p:11, r:22, y:33, dp:44, dr:55, dy:66, cal:0, k:10,
               res0:3, res1:-3, res2:200, ep:3, er:-3, ey:200, lat:34};
    tbl[6] = '{p:5, r:6, y:7, dp:8, dr:9, dy:10, cal:0, k:3,
               res0:20, res1:99, res2:-20, ep:20, er:0, ey:-20, lat:26};

    rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_seq(tbl[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // stray pid_done while IDLE
    pid_res = 10'sd77;
    pid_done = 1'b1;
    tick();
    pid_done = 1'b0;
    tick();
    check("idle_done_busy", busy, 0);
    check("idle_done_go", pid_go, 0);
    check("idle_done_tv", terms_vld, 0);
    check("idle_done_pterm", ptch_term, tbl[4].ep);
    check("idle_done_rterm", roll_term, tbl[4].er);
    check("idle_done_yterm", yaw_term, tbl[4].ey);

    // stray pid_done during each ISSUE cycle
    run_seq(tbl[0], 1'b0, 1'b1, 1'b0, 1'b0);

    // overrun: vld on every busy cycle (34 per sequence), nine sequences
    check("ovr_before", ovr_cnt, 0);
    run_seq(tbl[5], 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_one_seq", ovr_cnt, 34);
    for (int i = 0; i < 8; i++) begin
      run_seq(tbl[5], 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("ovr_saturated", ovr_cnt, 255);

    // reset while waiting on roll
    run_seq(tbl[0], 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (terms_vld) tv_cnt++;
    end
    check("abort_no_tv", tv_cnt, 0);
    check("abort_idle", busy, 0);
    run_seq(tbl[2], 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef AXIS_SCHED_TMO_EN
    run_seq(tbl[6], 1'b0, 1'b0, 1'b0, 1'b1);
    check("tmo_err_set", tmo_err, 1);
`else
    check("tmo_err_tied", tmo_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_sched.md
AXIS_SCHED -- requirements
Module: axis_sched

Interface
REQ-001 SHALL have parameter: TMO_CYC, 1024, cycles allowed in WAIT before an axis timeout.
REQ-002 SHALL have port: clk  input  1  50MHz system clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: vld  input  1  one-cycle pulse, new inertial sample.
REQ-005 SHALL have ports: ptch/roll/yaw  input  16 each  signed measured attitude.
REQ-006 SHALL have ports: d_ptch/d_roll/d_yaw  input  16 each  signed desired attitude.
REQ-007 SHALL have port: inertial_cal  input  1  calibration in progress.
REQ-008 SHALL have ports: pid_go  output  1, pid_axis  output  2, pid_act  output  16, pid_des  output  16  (request to the shared PID engine).
REQ-009 SHALL have ports: pid_done  input  1, pid_res  input  10  signed PID result.
REQ-010 SHALL have ports: ptch_term/roll_term/yaw_term  output  10 each  signed published terms.
REQ-011 SHALL have ports: terms_vld  output  1, busy  output  1, ovr_cnt  output  8, tmo_err  output  1.

Function
REQ-012 SHALL implement FSM with states IDLE, ISSUE, WAIT, PUBLISH.
REQ-013 IDLE: on vld with inertial_cal=0, capture all six attitude inputs into snapshot regs, set axis=0, go ISSUE next cycle.
REQ-014 IDLE: on vld with inertial_cal=1, load all three terms with 0, go PUBLISH; no PID request.
REQ-015 ISSUE: assert pid_go for exactly one cycle; pid_axis=axis (0 ptch, 1 roll, 2 yaw); pid_act/pid_des = snapshot pair for that axis; go WAIT.
REQ-016 pid_axis, pid_act and pid_des SHALL hold stable from ISSUE until the WAIT exit.
REQ-017 WAIT: on pid_done, store pid_res into the term reg of the current axis; axis<2 -> axis+1, go ISSUE; axis=2 -> go PUBLISH.
REQ-018 PUBLISH: terms_vld=1 for exactly one cycle, then IDLE; terms hold until next PUBLISH.
REQ-019 Latency: with pid_done k cycles after each pid_go, terms_vld occurs 3k+4 cycles after vld.
REQ-020 busy SHALL be 1 in every state other than IDLE.
REQ-021 vld while busy SHALL be ignored (snapshot unchanged) and increment ovr_cnt, saturating at 255.
REQ-022 pid_done outside WAIT SHALL be ignored.
REQ-023 vld and pid_done in the same cycle SHALL be handled independently (done per REQ-017, vld per REQ-021).
REQ-024 inertial_cal rising mid-sequence SHALL NOT abort it; it takes effect at the next vld.

Reset
REQ-025 Reset SHALL force IDLE, axis=0, pid_go=0, terms_vld=0, busy=0.
REQ-026 Reset SHALL clear all terms, snapshots, pid_act, pid_des, pid_axis, ovr_cnt, tmo_err and the timeout counter to 0.
REQ-027 Reset asserted mid-sequence SHALL abandon it; no terms_vld is produced for that sample.

Configuration
REQ-028 Macro AXIS_SCHED_TMO_EN defined: a counter runs in WAIT, cleared on entry; if TMO_CYC cycles elapse without pid_done, store 0 for that axis, set tmo_err (sticky until reset), proceed per REQ-017.
REQ-029 Macro AXIS_SCHED_TMO_EN undefined: no counter; WAIT persists until pid_done; tmo_err tied 0.

Verification
REQ-030 Scenario: vld with ptch=100,d_ptch=40,roll=-20,d_roll=0,yaw=7,d_yaw=7; PID model returns 12,-5,0 after k=3 -> pid_axis 0,1,2 in order, terms 12/-5/0, terms_vld 13 cycles after vld.
REQ-031 Scenario: vld with inertial_cal=1 -> no pid_go, terms all 0, terms_vld 2 cycles after vld.
REQ-032 Scenario: 300 vld pulses during busy sequences -> ovr_cnt=255, snapshots unchanged, sequence results intact.
REQ-033 Scenario (AXIS_SCHED_TMO_EN, TMO_CYC=16): never assert pid_done for roll -> roll_term=0, tmo_err=1, yaw still issued, terms_vld produced.
REQ-034 Scenario: assert rst_n=0 in WAIT for axis 1 -> all outputs 0, IDLE; next vld completes normally.
REQ-035 Scenario: pulse pid_done in IDLE and ISSUE -> ignored, terms unchanged, no state change.
